pipeline_hazard_ctrl: RTL and testbench

//  Central hazard/forwarding controller for the 3-stage RV32I pipeline (F/D -> X -> WB).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 51 +++++
 rtl/hazard_reg_use.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and decode types for the 3-stage RV32I hazard/forwarding controller.
// Opcodes, NOP word, forwarding-select and FSM encodings live here.
package pipeline_hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_RT  = 2'd2;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LD_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam int BUB_W = 2;

    typedef struct packed {
        logic       is_load;
        logic       has_rd;
        logic       has_rs1;
        logic       has_rs2;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } reg_use_t;

    // WB results win over the retired load because they are younger; x0 never forwards.
    function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                              input reg_use_t   wb,
                                              input reg_use_t   rt);
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != 5'd0 && wb.has_rd && !wb.is_load && wb.rd == src) begin
            sel = FWD_WB;
        end else if (src != 5'd0 && rt.is_load && rt.rd == src) begin
            sel = FWD_RT;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_reg_use.sv
// Register-usage decoder: which architectural registers an instruction word reads and writes.
module hazard_reg_use
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output reg_use_t    dec
);

    logic [6:0] opcode;

    assign opcode = inst[6:0];

    always_comb begin
        dec         = '0;
        dec.is_load = (opcode == OPC_LOAD);
        dec.has_rd  = !((opcode == OPC_BRANCH) || (opcode == OPC_STORE));
        dec.has_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
        dec.has_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the F/D -> X -> WB pipeline: shadows X/WB/RT words and
// owns every stall, flush and operand-forwarding decision.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int          LOAD_USE_BUBBLES = 1,
    parameter logic [31:0] NOP              = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_f,
    input  logic        inst_valid_f,
    input  logic        br_taken_x,
    input  logic        dmem_busy,
    output logic        pc_stall,
    output logic        flush_f,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [31:0] inst_x,
    output logic [31:0] inst_wb
);

    localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(LOAD_USE_BUBBLES - 1);

    logic [31:0]      inst_x_q, inst_x_d;
    logic [31:0]      inst_wb_q, inst_wb_d;
    logic [31:0]      inst_rt_q, inst_rt_d;
    logic [1:0]       state_q, state_d;
    logic [BUB_W-1:0] bub_cnt_q, bub_cnt_d;

    reg_use_t dec_f, dec_x, dec_wb, dec_rt;
    logic     load_use;
    logic     unused_dec;

    hazard_reg_use u_use_f  (.inst(inst_f),    .dec(dec_f));
    hazard_reg_use u_use_x  (.inst(inst_x_q),  .dec(dec_x));
    hazard_reg_use u_use_wb (.inst(inst_wb_q), .dec(dec_wb));
    hazard_reg_use u_use_rt (.inst(inst_rt_q), .dec(dec_rt));

    assign unused_dec = ^{dec_f, dec_x, dec_wb, dec_rt};

    assign fwd_a_sel = fwd_select(dec_x.rs1, dec_wb, dec_rt);
    assign fwd_b_sel = fwd_select(dec_x.rs2, dec_wb, dec_rt);

    assign load_use = dec_x.is_load && (dec_x.rd != 5'd0) &&
                      ((dec_f.has_rs1 && dec_f.rs1 == dec_x.rd) ||
                       (dec_f.has_rs2 && dec_f.rs2 == dec_x.rd));

    always_comb begin
        inst_x_d  = inst_x_q;
        inst_wb_d = inst_wb_q;
        inst_rt_d = inst_rt_q;
        state_d   = state_q;
        bub_cnt_d = bub_cnt_q;
        pc_stall  = 1'b0;
        flush_f   = 1'b0;

        if (dmem_busy) begin
            pc_stall = 1'b1;
        end else begin
            inst_rt_d = inst_wb_q;
            inst_wb_d = inst_x_q;
            inst_x_d  = NOP;
            // A taken branch overrides any stall bookkeeping; FLUSH then covers the imem latency.
            if (br_taken_x) begin
                flush_f   = 1'b1;
                state_d   = ST_FLUSH;
                bub_cnt_d = '0;
            end else begin
                case (state_q)
                    ST_FLUSH: begin
                        flush_f = 1'b1;
                        state_d = ST_RUN;
                    end
                    ST_LD_STALL: begin
                        pc_stall  = 1'b1;
                        bub_cnt_d = bub_cnt_q - 1'b1;
                        if (bub_cnt_q <= BUB_W'(1)) begin
                            bub_cnt_d = '0;
                            state_d   = ST_RUN;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        if (load_use) begin
                            pc_stall  = 1'b1;
                            bub_cnt_d = BUB_INIT;
                            state_d   = (BUB_INIT != '0) ? ST_LD_STALL : ST_RUN;
                        end else begin
                            inst_x_d = inst_valid_f ? inst_f : NOP;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_x_q  <= NOP;
            inst_wb_q <= NOP;
            inst_rt_q <= NOP;
            state_q   <= ST_RUN;
            bub_cnt_q <= '0;
        end else begin
            inst_x_q  <= inst_x_d;
            inst_wb_q <= inst_wb_d;
            inst_rt_q <= inst_rt_d;
            state_q   <= state_d;
            bub_cnt_q <= bub_cnt_d;
        end
    end

    assign inst_x  = inst_x_q;
    assign inst_wb = inst_wb_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-level
// reference model, driving a 1-bubble and a 3-bubble controller side by side.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_f;
    logic        inst_valid_f;
    logic        br_taken_x;
    logic        dmem_busy;

    logic        pc_stall1, flush_f1, pc_stall3, flush_f3;
    logic [1:0]  fwd_a1, fwd_b1, fwd_a3, fwd_b3;
    logic [31:0] inst_x1, inst_wb1, inst_x3, inst_wb3;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .inst_f(inst_f), .inst_valid_f(inst_valid_f),
        .br_taken_x(br_taken_x), .dmem_busy(dmem_busy), .pc_stall(pc_stall1),
        .flush_f(flush_f1), .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1),
        .inst_x(inst_x1), .inst_wb(inst_wb1)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(3)) dut3 (
        .clk(clk), .rst(rst), .inst_f(inst_f), .inst_valid_f(inst_valid_f),
        .br_taken_x(br_taken_x), .dmem_busy(dmem_busy), .pc_stall(pc_stall3),
        .flush_f(flush_f3), .fwd_a_sel(fwd_a3), .fwd_b_sel(fwd_b3),
        .inst_x(inst_x3), .inst_wb(inst_wb3)
    );

    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2, input logic [6:0] f7);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_b(input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'b1100011};
    endfunction

    // Reference-model view of an instruction word
    function automatic bit m_writes(input logic [31:0] w);
        return !(w[6:0] == 7'b1100011 || w[6:0] == 7'b0100011);
    endfunction
    function automatic bit m_reads1(input logic [31:0] w);
        return !(w[6:0] == 7'b0110111 || w[6:0] == 7'b0010111 || w[6:0] == 7'b1101111);
    endfunction
    function automatic bit m_reads2(input logic [31:0] w);
        return (w[6:0] == 7'b1100011 || w[6:0] == 7'b0100011 || w[6:0] == 7'b0110011);
    endfunction
    function automatic bit m_is_load(input logic [31:0] w);
        return w[6:0] == 7'b0000011;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input logic [31:0] wb, input logic [31:0] rt);
        if (src == 0) return 2'd0;
        if (m_writes(wb) && !m_is_load(wb) && wb[11:7] == src) return 2'd1;
        if (m_is_load(rt) && rt[11:7] == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_load_use(input logic [31:0] x, input logic [31:0] f);
        if (!m_is_load(x) || x[11:7] == 0) return 1'b0;
        return (m_reads1(f) && f[19:15] == x[11:7]) || (m_reads2(f) && f[24:20] == x[11:7]);
    endfunction

    task automatic drive(input logic [31:0] f, input logic v, input logic br, input logic busy);
        inst_f       = f;
        inst_valid_f = v;
        br_taken_x   = br;
        dmem_busy    = busy;
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(NOPW, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(NOPW, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({pc_stall1, flush_f1, fwd_a1, fwd_b1} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_comb1 got=%b exp=000000", {pc_stall1, flush_f1, fwd_a1, fwd_b1});
        end
        checks++;
        if ({pc_stall3, flush_f3, fwd_a3, fwd_b3} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_comb3 got=%b exp=000000", {pc_stall3, flush_f3, fwd_a3, fwd_b3});
        end
        checks++;
        if (inst_x1 !== NOPW || inst_wb1 !== NOPW) begin
            failures++;
            $display("[TB] FAIL reset_words x=%h wb=%h exp=%h", inst_x1, inst_wb1, NOPW);
        end
    endtask

    task automatic test_alu_hazard();
        logic [31:0] add5, sub6;
        int stalls;
        add5   = enc_r(5, 1, 2, 7'b0);
        sub6   = enc_r(6, 5, 3, 7'b0100000);
        stalls = 0;
        do_reset();
        drive(add5, 1'b1, 1'b0, 1'b0);
        if (pc_stall1) stalls++;
        next_cycle();
        drive(sub6, 1'b1, 1'b0, 1'b0);
        if (pc_stall1) stalls++;
        next_cycle();
        drive(NOPW, 1'b0, 1'b0, 1'b0);
        if (pc_stall1) stalls++;
        checks++;
        if (fwd_a1 !== 2'd1 || fwd_b1 !== 2'd0) begin
            failures++;
            $display("[TB] FAIL alu_fwd got a=%0d b=%0d exp a=1 b=0", fwd_a1, fwd_b1);
        end
        checks++;
        if (inst_x1 !== sub6 || inst_wb1 !== add5) begin
            failures++;
            $display("[TB] FAIL alu_words x=%h wb=%h exp x=%h wb=%h", inst_x1, inst_wb1, sub6, add5);
        end
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("[TB] FAIL alu_no_stall got=%0d exp=0", stalls);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] lw7, add8;
        int stalls1, stalls3, ld3;
        lw7  = enc_i(7'b0000011, 3'b010, 7, 1, 0);
        add8 = enc_r(8, 7, 7, 7'b0);
        stalls1 = 0; stalls3 = 0; ld3 = 0;
        do_reset();
        drive(lw7, 1'b1, 1'b0, 1'b0);
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            drive(add8, 1'b1, 1'b0, 1'b0);
            if (pc_stall1) stalls1++;
            if (pc_stall3) stalls3++;
            if (dut3.state_q == ST_LD_STALL) ld3++;
            if (c == 0) begin
                checks++;
                if (pc_stall1 !== 1'b1 || pc_stall3 !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL lu_detect got=%b%b exp=11", pc_stall1, pc_stall3);
                end
            end
            if (c == 1) begin
                checks++;
                if (inst_x1 !== NOPW || inst_x3 !== NOPW || inst_wb1 !== lw7) begin
                    failures++;
                    $display("[TB] FAIL lu_bubble x1=%h x3=%h wb1=%h exp x=%h wb=%h",
                             inst_x1, inst_x3, inst_wb1, NOPW, lw7);
                end
            end
            if (c == 2) begin
                checks++;
                if (fwd_a1 !== 2'd2 || fwd_b1 !== 2'd2 || inst_x1 !== add8) begin
                    failures++;
                    $display("[TB] FAIL lu_fwd_rt got a=%0d b=%0d x=%h exp a=2 b=2 x=%h",
                             fwd_a1, fwd_b1, inst_x1, add8);
                end
            end
            if (c == 4) begin
                checks++;
                if (inst_x3 !== add8 || fwd_a3 !== 2'd0) begin
                    failures++;
                    $display("[TB] FAIL lu3_accept got x=%h a=%0d exp x=%h a=0", inst_x3, fwd_a3, add8);
                end
            end
            next_cycle();
        end
        checks++;
        if (stalls1 != 1) begin
            failures++;
            $display("[TB] FAIL lu1_stall_cycles got=%0d exp=1", stalls1);
        end
        checks++;
        if (stalls3 != 3 || ld3 != 2) begin
            failures++;
            $display("[TB] FAIL lu3_stall_cycles got stall=%0d ld=%0d exp stall=3 ld=2", stalls3, ld3);
        end
    endtask

    task automatic test_x0_suppress();
        logic [31:0] addi0, add9, lw0;
        addi0 = enc_i(7'b0010011, 3'b000, 0, 1, 5);
        add9  = enc_r(9, 0, 0, 7'b0);
        lw0   = enc_i(7'b0000011, 3'b010, 0, 1, 0);
        do_reset();
        drive(addi0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(add9, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(lw0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fwd_a1 !== 2'd0 || fwd_b1 !== 2'd0 || pc_stall1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_fwd got a=%0d b=%0d stall=%b exp 0 0 0", fwd_a1, fwd_b1, pc_stall1);
        end
        next_cycle();
        drive(add9, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc_stall1 !== 1'b0 || pc_stall3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL x0_load_no_stall got=%b%b exp=00", pc_stall1, pc_stall3);
        end
        next_cycle();
    endtask

    task automatic test_branch_flush();
        logic [31:0] beq, add3, lw7, add8;
        beq  = enc_b(1, 2);
        add3 = enc_r(3, 4, 5, 7'b0);
        lw7  = enc_i(7'b0000011, 3'b010, 7, 1, 0);
        add8 = enc_r(8, 7, 7, 7'b0);
        do_reset();
        drive(beq, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(add3, 1'b1, 1'b1, 1'b0);
        checks++;
        if (flush_f1 !== 1'b1 || pc_stall1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL br_flush0 got flush=%b stall=%b exp 1 0", flush_f1, pc_stall1);
        end
        next_cycle();
        drive(add3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (flush_f1 !== 1'b1 || inst_x1 !== NOPW || inst_wb1 !== beq) begin
            failures++;
            $display("[TB] FAIL br_flush1 got flush=%b x=%h wb=%h exp 1 %h %h", flush_f1, inst_x1, inst_wb1, NOPW, beq);
        end
        next_cycle();
        drive(add3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (flush_f1 !== 1'b0 || inst_x1 !== NOPW) begin
            failures++;
            $display("[TB] FAIL br_flush_end got flush=%b x=%h exp 0 %h", flush_f1, inst_x1, NOPW);
        end
        next_cycle();
        drive(NOPW, 1'b0, 1'b0, 1'b0);
        checks++;
        if (inst_x1 !== add3) begin
            failures++;
            $display("[TB] FAIL br_resume got=%h exp=%h", inst_x1, add3);
        end

        // Branch and load-use in the same cycle: the flush must win.
        do_reset();
        drive(lw7, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(add8, 1'b1, 1'b1, 1'b0);
        checks++;
        if (flush_f3 !== 1'b1 || pc_stall3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL br_vs_lu got flush=%b stall=%b exp 1 0", flush_f3, pc_stall3);
        end
        next_cycle();
        drive(add8, 1'b1, 1'b0, 1'b0);
        checks++;
        if (flush_f3 !== 1'b1 || pc_stall3 !== 1'b0 || dut3.state_q !== ST_FLUSH) begin
            failures++;
            $display("[TB] FAIL br_vs_lu_next got flush=%b stall=%b st=%0d exp 1 0 %0d",
                     flush_f3, pc_stall3, dut3.state_q, ST_FLUSH);
        end
        next_cycle();
        drive(add8, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pc_stall3 !== 1'b0 || flush_f3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL br_vs_lu_run got flush=%b stall=%b exp 0 0", flush_f3, pc_stall3);
        end
        next_cycle();
    endtask

    task automatic test_dmem_freeze();
        logic [31:0] lw7, add8;
        int stalls;
        lw7  = enc_i(7'b0000011, 3'b010, 7, 1, 0);
        add8 = enc_r(8, 7, 7, 7'b0);
        do_reset();
        drive(lw7, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(add8, 1'b1, 1'b0, 1'b0);
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            drive(add8, 1'b1, (c == 1), 1'b1);
            checks++;
            if (pc_stall3 !== 1'b1 || flush_f3 !== 1'b0) begin
                failures++;
                $display("[TB] FAIL freeze_comb c=%0d got stall=%b flush=%b exp 1 0", c, pc_stall3, flush_f3);
            end
            next_cycle();
            checks++;
            if (inst_x3 !== NOPW || inst_wb3 !== lw7 || dut3.bub_cnt_q !== 2'd2 || dut3.state_q !== ST_LD_STALL) begin
                failures++;
                $display("[TB] FAIL freeze_hold c=%0d got x=%h wb=%h cnt=%0d st=%0d exp %h %h 2 %0d",
                         c, inst_x3, inst_wb3, dut3.bub_cnt_q, dut3.state_q, NOPW, lw7, ST_LD_STALL);
            end
        end
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            drive(add8, 1'b1, 1'b0, 1'b0);
            if (pc_stall3) stalls++;
            next_cycle();
        end
        checks++;
        if (stalls != 2 || inst_x3 !== add8) begin
            failures++;
            $display("[TB] FAIL freeze_resume got stalls=%0d x=%h exp 2 %h", stalls, inst_x3, add8);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] lw7, add8;
        lw7  = enc_i(7'b0000011, 3'b010, 7, 1, 0);
        add8 = enc_r(8, 7, 7, 7'b0);
        do_reset();
        drive(lw7, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(add8, 1'b1, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b1;
        drive(add8, 1'b1, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        drive(add8, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dut3.state_q !== ST_RUN || inst_x3 !== NOPW || pc_stall3 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_stall got st=%0d x=%h stall=%b exp %0d %h 0",
                     dut3.state_q, inst_x3, pc_stall3, ST_RUN, NOPW);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [6:0]  ops [8];
        logic [31:0] mx [2], mwb [2], mrt [2];
        int          left [2], nb [2];
        bit          mflush [2];
        logic [31:0] w;
        logic        v, br, busy, r;
        bit          lu, e_pc, e_fl;
        logic [1:0]  e_a, e_b;
        logic        a_pc, a_fl;
        logic [1:0]  a_a, a_b;
        logic [31:0] a_x, a_wb;

        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                7'b0010011, 7'b0110111, 7'b1101111, 7'b0010111};
        nb  = '{1, 3};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = NOPW; mwb[k] = NOPW; mrt[k] = NOPW; left[k] = 0; mflush[k] = 1'b0;
        end

        for (int cyc = 0; cyc < 600; cyc++) begin
            w        = $urandom;
            w[6:0]   = ops[$urandom_range(0, 7)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            v    = ($urandom_range(0, 99) < 85);
            br   = ($urandom_range(0, 99) < 8);
            busy = ($urandom_range(0, 99) < 10);
            r    = ($urandom_range(0, 99) < 2);
            rst  = r;
            drive(w, v, br, busy);

            for (int k = 0; k < 2; k++) begin
                a_pc = k == 1 ? pc_stall3 : pc_stall1;
                a_fl = k == 1 ? flush_f3  : flush_f1;
                a_a  = k == 1 ? fwd_a3    : fwd_a1;
                a_b  = k == 1 ? fwd_b3    : fwd_b1;
                a_x  = k == 1 ? inst_x3   : inst_x1;
                a_wb = k == 1 ? inst_wb3  : inst_wb1;

                lu   = m_load_use(mx[k], w);
                e_a  = m_fwd(mx[k][19:15], mwb[k], mrt[k]);
                e_b  = m_fwd(mx[k][24:20], mwb[k], mrt[k]);
                e_pc = 1'b0;
                e_fl = 1'b0;
                if (busy) e_pc = 1'b1;
                else if (br || mflush[k]) e_fl = 1'b1;
                else if (left[k] > 0 || lu) e_pc = 1'b1;

                checks++;
                if (a_pc !== e_pc || a_fl !== e_fl) begin
                    failures++;
                    $display("[TB] FAIL rand_ctrl b=%0d cyc=%0d got stall=%b flush=%b exp %b %b",
                             nb[k], cyc, a_pc, a_fl, e_pc, e_fl);
                end
                checks++;
                if (a_a !== e_a || a_b !== e_b) begin
                    failures++;
                    $display("[TB] FAIL rand_fwd b=%0d cyc=%0d got a=%0d b=%0d exp %0d %0d",
                             nb[k], cyc, a_a, a_b, e_a, e_b);
                end
                checks++;
                if (a_x !== mx[k] || a_wb !== mwb[k]) begin
                    failures++;
                    $display("[TB] FAIL rand_words b=%0d cyc=%0d got x=%h wb=%h exp %h %h",
                             nb[k], cyc, a_x, a_wb, mx[k], mwb[k]);
                end

                if (r) begin
                    mx[k] = NOPW; mwb[k] = NOPW; mrt[k] = NOPW; left[k] = 0; mflush[k] = 1'b0;
                end else if (!busy) begin
                    mrt[k] = mwb[k];
                    mwb[k] = mx[k];
                    if (br) begin
                        mx[k] = NOPW; mflush[k] = 1'b1; left[k] = 0;
                    end else if (mflush[k]) begin
                        mx[k] = NOPW; mflush[k] = 1'b0;
                    end else if (left[k] > 0) begin
                        mx[k] = NOPW; left[k]--;
                    end else if (lu) begin
                        mx[k] = NOPW; left[k] = nb[k] - 1;
                    end else begin
                        mx[k] = v ? w : NOPW;
                    end
                end
            end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        inst_f       = NOPW;
        inst_valid_f = 1'b0;
        br_taken_x   = 1'b0;
        dmem_busy    = 1'b0;
        test_reset();
        test_alu_hazard();
        test_load_use();
        test_x0_suppress();
        test_branch_flush();
        test_dmem_freeze();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
